// File: rtl/pingpong_transpose_buf.sv
// Two-bank ping-pong frame buffer: row-major writes into one bank, column-major reads from the other.
// Optional s_last framing check is enabled by defining PPBUF_LAST_CHK_EN.
module pingpong_transpose_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 4,
  parameter int COLS       = 8,
  parameter int ADDRW      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [1:0]            bank_full,
  output logic                  frame_err
);

  localparam int ROWW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COLW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DEPTH = 1 << ADDRW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_e;

  logic [DATA_WIDTH-1:0] bank0_ram [DEPTH];
  logic [DATA_WIDTH-1:0] bank1_ram [DEPTH];

  logic            wr_bank_q, wr_bank_d;
  logic [ROWW-1:0] wr_row_q, wr_row_d;
  logic [COLW-1:0] wr_col_q, wr_col_d;
  logic [1:0]      bank_full_q, bank_full_d;

  rd_state_e       rd_state_q, rd_state_d;
  logic            rd_bank_q, rd_bank_d;
  logic [ROWW-1:0] rd_row_q, rd_row_d;
  logic [COLW-1:0] rd_col_q, rd_col_d;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;

  logic [DATA_WIDTH-1:0] sk_data_q [2];
  logic [DATA_WIDTH-1:0] sk_data_d [2];
  logic [1:0]            sk_last_q, sk_last_d;
  logic [1:0]            sk_cnt_q, sk_cnt_d;
  logic [1:0]            sk_fill;

  logic             wr_fire, wr_final, rd_final, rd_issue, pop;
  logic [1:0]       occ_after;
  logic [ADDRW-1:0] wr_addr, rd_addr;

  assign s_ready   = !bank_full_q[wr_bank_q];
  assign bank_full = bank_full_q;

  assign wr_fire  = s_valid && s_ready;
  assign wr_final = (wr_row_q == ROWW'(ROWS - 1)) && (wr_col_q == COLW'(COLS - 1));
  assign rd_final = (rd_row_q == ROWW'(ROWS - 1)) && (rd_col_q == COLW'(COLS - 1));
  assign wr_addr  = ADDRW'(wr_row_q) * ADDRW'(COLS) + ADDRW'(wr_col_q);
  assign rd_addr  = ADDRW'(rd_row_q) * ADDRW'(COLS) + ADDRW'(rd_col_q);

  // Skid entries are older than the RAM output register, so they are presented first.
  assign m_valid = (sk_cnt_q != 2'd0) || rvalid_q;
  assign m_data  = (sk_cnt_q != 2'd0) ? sk_data_q[0] : (rvalid_q ? rdata_q : '0);
  assign m_last  = (sk_cnt_q != 2'd0) ? sk_last_q[0] : (rvalid_q && rlast_q);
  assign pop     = m_valid && m_ready;

  // A read may issue only if the data it returns is guaranteed a slot next cycle.
  assign occ_after = sk_cnt_q + {1'b0, rvalid_q} - {1'b0, pop};
  assign rd_issue  = (rd_state_q == RUN) && (occ_after <= 2'd1);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wr_bank_q) bank1_ram[wr_addr] <= s_data;
      else           bank0_ram[wr_addr] <= s_data;
    end
    if (rd_issue) rdata_q <= rd_bank_q ? bank1_ram[rd_addr] : bank0_ram[rd_addr];
  end

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    bank_full_d = bank_full_q;
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;

    if (wr_fire) begin
      if (wr_final) begin
        wr_row_d               = '0;
        wr_col_d               = '0;
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = !wr_bank_q;
      end else if (wr_col_q == COLW'(COLS - 1)) begin
        wr_col_d = '0;
        wr_row_d = wr_row_q + 1'b1;
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end

    case (rd_state_q)
      IDLE: begin
        if (bank_full_q[rd_bank_q]) rd_state_d = RUN;
      end
      RUN: begin
        if (rd_issue) begin
          if (rd_final) begin
            rd_row_d   = '0;
            rd_col_d   = '0;
            rd_state_d = DRAIN;
          end else if (rd_row_q == ROWW'(ROWS - 1)) begin
            rd_row_d = '0;
            rd_col_d = rd_col_q + 1'b1;
          end else begin
            rd_row_d = rd_row_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = !rd_bank_q;
          rd_state_d             = IDLE;
        end
      end
      default: rd_state_d = IDLE;
    endcase
  end

  always_comb begin
    rvalid_d  = rd_issue;
    rlast_d   = rd_issue && rd_final;
    sk_data_d = sk_data_q;
    sk_last_d = sk_last_q;
    sk_fill   = sk_cnt_q;
    if (pop && (sk_cnt_q != 2'd0)) begin
      sk_data_d[0] = sk_data_q[1];
      sk_last_d[0] = sk_last_q[1];
      sk_fill      = sk_fill - 2'd1;
    end
    // RAM output moves into the skid unless it is being consumed directly this cycle.
    if (rvalid_q && !(pop && (sk_cnt_q == 2'd0))) begin
      if (sk_fill == 2'd0) begin
        sk_data_d[0] = rdata_q;
        sk_last_d[0] = rlast_q;
      end else begin
        sk_data_d[1] = rdata_q;
        sk_last_d[1] = rlast_q;
      end
      sk_fill = sk_fill + 2'd1;
    end
    sk_cnt_d = sk_fill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q    <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      bank_full_q  <= 2'b00;
      rd_state_q   <= IDLE;
      rd_bank_q    <= 1'b0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      sk_data_q[0] <= '0;
      sk_data_q[1] <= '0;
      sk_last_q    <= 2'b00;
      sk_cnt_q     <= 2'd0;
    end else begin
      wr_bank_q    <= wr_bank_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      bank_full_q  <= bank_full_d;
      rd_state_q   <= rd_state_d;
      rd_bank_q    <= rd_bank_d;
      rd_row_q     <= rd_row_d;
      rd_col_q     <= rd_col_d;
      rvalid_q     <= rvalid_d;
      rlast_q      <= rlast_d;
      sk_data_q[0] <= sk_data_d[0];
      sk_data_q[1] <= sk_data_d[1];
      sk_last_q    <= sk_last_d;
      sk_cnt_q     <= sk_cnt_d;
    end
  end

`ifdef PPBUF_LAST_CHK_EN
  logic frame_err_q, frame_err_d;

  always_comb begin
    frame_err_d = frame_err_q;
    if (wr_fire && (s_last != wr_final)) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`else
  // Check disabled: s_last is deliberately ignored and the error flag reads as zero.
  assign frame_err = s_last & 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_transpose_buf.sv
// Randomized self-checking bench for pingpong_transpose_buf; a frame-level model predicts the
// column-major output stream, and frame_err expectations follow PPBUF_LAST_CHK_EN.
module tb_pingpong_transpose_buf;

  localparam int DW   = 32;
  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int FR   = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready_manual = 1'b0;
  logic          m_ready_rand = 1'b0;
  logic          rand_ready = 1'b0;
  wire           m_ready = rand_ready ? m_ready_rand : m_ready_manual;
  logic          m_last;
  logic [1:0]    bank_full;
  logic          frame_err;

  int assertCount = 0;
  int failCount = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] wr_buf [FR];
  int            wr_cnt = 0;
  int            wr_frames = 0;
  int            out_idx = 0;
  int            first_cyc = 0;
  int            cyc = 0;
  bit            prev_stall = 1'b0;
  bit            contig_mode = 1'b0;
  logic          exp_err;

  pingpong_transpose_buf #(
    .DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .ADDRW(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .bank_full(bank_full), .frame_err(frame_err)
  );

  always #5 clk = !clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    assertCount++;
    if (obs !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic last);
    int guard;
    guard = 0;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) checkOutput("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic writeFrame(input int base, input bit rnd, input int err_idx);
    for (int i = 0; i < FR; i++)
      applyStimulus(rnd ? DW'($urandom) : DW'(base + i), (i == FR - 1) || (i == err_idx));
  endtask

  task automatic resetDut();
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic waitDrain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || m_valid) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    checkOutput("drain_done", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    checkOutput({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    checkOutput({tag, "_m_last"}, 32'(m_last), 32'd0);
    checkOutput({tag, "_m_data"}, m_data, 32'd0);
    checkOutput({tag, "_bank_full"}, 32'(bank_full), 32'd0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      m_ready_rand = ($urandom_range(0, 1) == 1);
    end
  end

  // Reference model: collect accepted samples per frame, then queue the frame in column-major order.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      wr_cnt     = 0;
      wr_frames  = 0;
      out_idx    = 0;
      prev_stall = 1'b0;
    end else begin
      if (s_valid && s_ready) begin
        wr_buf[wr_cnt] = s_data;
        wr_cnt++;
        if (wr_cnt == FR) begin
          for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
              exp_q.push_back({(c == COLS - 1) && (r == ROWS - 1), wr_buf[r * COLS + c]});
          wr_cnt = 0;
          wr_frames++;
        end
      end
      if (prev_stall) checkOutput("m_valid_hold", 32'(m_valid), 32'd1);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_valid", 32'(m_valid), 32'd0);
        end else begin
          checkOutput("m_data", m_data, exp_q[0][DW-1:0]);
          checkOutput("m_last", 32'(m_last), 32'(exp_q[0][DW]));
          if (m_ready) begin
            void'(exp_q.pop_front());
            if (out_idx == 0) first_cyc = cyc;
            if (out_idx == FR - 1 && contig_mode)
              checkOutput("frame_contig", 32'(cyc - first_cyc), 32'(FR - 1));
            out_idx = (out_idx + 1) % FR;
          end
        end
      end
      prev_stall = m_valid && !m_ready;
    end
  end

  initial begin
`ifdef PPBUF_LAST_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    @(negedge clk);
    checkResetValues("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] single frame, latency and order");
    m_ready_manual = 1'b1;
    writeFrame(0, 1'b0, -1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    checkOutput("lat_edge0", 32'(m_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_edge1", 32'(m_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_edge2", 32'(m_valid), 32'd1);
    checkOutput("first_data", m_data, 32'd0);
    waitDrain();

    $display("[TB] back-pressure with both banks full");
    resetDut();
    m_ready_manual = 1'b0;
    writeFrame(0, 1'b0, -1);
    writeFrame(100, 1'b0, -1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    checkOutput("both_full", 32'(bank_full), 32'd3);
    checkOutput("stall_ready", 32'(s_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("still_full", 32'(bank_full), 32'd3);
    m_ready_manual = 1'b1;
    begin
      int g;
      g = 0;
      @(negedge clk);
      while (bank_full[0] && g < 200) begin
        @(negedge clk);
        g++;
      end
      checkOutput("release_ready", 32'(s_ready), 32'd1);
      checkOutput("release_bank1", 32'(bank_full[1]), 32'd1);
    end
    writeFrame(200, 1'b0, -1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    checkOutput("frame3_bank0", 32'(bank_full[0]), 32'd1);
    waitDrain();

    $display("[TB] random m_ready during readout");
    resetDut();
    rand_ready = 1'b1;
    writeFrame(0, 1'b0, -1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    waitDrain();
    rand_ready = 1'b0;
    m_ready_manual = 1'b1;

    $display("[TB] continuous streaming of 10 frames");
    resetDut();
    contig_mode = 1'b1;
    for (int f = 0; f < 10; f++) begin
      writeFrame(0, 1'b1, -1);
      checkOutput("bank_alternate", 32'(bank_full[(wr_frames - 1) % 2]), 32'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    waitDrain();
    contig_mode = 1'b0;

    $display("[TB] reset in the middle of a frame");
    resetDut();
    for (int i = 0; i < 13; i++) applyStimulus(DW'($urandom), 1'b0);
    s_valid = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkResetValues("midrst");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    writeFrame(0, 1'b0, -1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    waitDrain();

    $display("[TB] s_last framing check");
    resetDut();
    for (int i = 0; i < FR; i++) begin
      applyStimulus(DW'(i), (i == 20) || (i == FR - 1));
      if (i == 19) checkOutput("frame_err_before", 32'(frame_err), 32'd0);
      if (i == 20) checkOutput("frame_err_set", 32'(frame_err), 32'(exp_err));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    waitDrain();
    checkOutput("frame_err_sticky", 32'(frame_err), 32'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
